// File: rtl/mul_repadd_pkg.sv
// Shared definitions for the repeated-addition multiplier.
//   state_t   : controller state encoding (IDLE, RUN, DONE)
//   MUL_WIDTH : default operand width
package mul_repadd_pkg;

   localparam int MUL_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/zero_det_n.sv
// Combinational WIDTH-bit equality-to-zero detector.
//   din  : value under test
//   zero : 1 when din is all zeros
module zero_det_n #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] din,
   output logic             zero
);

   assign zero = (din == '0);

endmodule

// File: rtl/mul_repadd_seq.sv
// Sequential unsigned multiplier by repeated addition.
// An accepted start latches a loop count and an addend, then adds the addend
// into a 2*WIDTH accumulator once per RUN cycle until the count is exhausted.
// A zero operand skips RUN entirely.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start    : request, only honoured in IDLE
//   a, b     : operands, sampled on the accepted start edge
//   product  : result, loaded on entry to DONE and held afterwards
//   done     : one-cycle pulse while in DONE
//   busy     : high while in RUN
module mul_repadd_seq #(
   parameter int WIDTH    = mul_repadd_pkg::MUL_WIDTH,
   parameter bit SWAP_MIN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               done,
   output logic               busy
);
   import mul_repadd_pkg::*;

   state_t               state, nstate;
   logic [2*WIDTH-1:0]   acc, acc_nxt;
   logic [WIDTH-1:0]     cnt, addend, cnt_m1;
   logic [WIDTH-1:0]     cnt_ld, addend_ld;
   logic                 a_zero, b_zero, cnt_last;

   assign cnt_m1  = cnt - WIDTH'(1);
   assign acc_nxt = acc + {{WIDTH{1'b0}}, addend};

   // cnt_last fires on the final iteration: cnt==1 so cnt-1 is zero.
   zero_det_n #(.WIDTH(WIDTH)) u_zd_cnt (.din(cnt_m1), .zero(cnt_last));
   zero_det_n #(.WIDTH(WIDTH)) u_zd_a   (.din(a),      .zero(a_zero));
   zero_det_n #(.WIDTH(WIDTH)) u_zd_b   (.din(b),      .zero(b_zero));

   // Iterate on the smaller operand when enabled; ties keep b as the count.
   always_comb begin
      cnt_ld    = b;
      addend_ld = a;
      if (SWAP_MIN && (a < b)) begin
         cnt_ld    = a;
         addend_ld = b;
      end
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE: if (start) nstate = (a_zero || b_zero) ? DONE : RUN;
         RUN:  if (cnt_last) nstate = DONE;
         DONE: nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         addend  <= '0;
         product <= '0;
      end else begin
         state <= nstate;
         case (state)
            IDLE: if (start) begin
               acc    <= '0;
               cnt    <= cnt_ld;
               addend <= addend_ld;
               if (a_zero || b_zero) product <= '0;
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt_m1;
               // Load the final sum directly so product is valid with done.
               if (cnt_last) product <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_repadd_seq.sv
// Bench for mul_repadd_seq: one instance per SWAP_MIN setting, each checked
// every cycle against an operation-level model (loop count, a*b, timing).
module tb_mul_repadd_seq;
   localparam int W = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             start;
   logic [1:0][W-1:0]      a, b;
   logic [1:0][2*W-1:0]    product;
   logic [1:0]             done, busy;

   always #5 clk = ~clk;

   mul_repadd_seq #(.WIDTH(W), .SWAP_MIN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]),
      .product(product[0]), .done(done[0]), .busy(busy[0]));

   mul_repadd_seq #(.WIDTH(W), .SWAP_MIN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]),
      .product(product[1]), .done(done[1]), .busy(busy[1]));

   int vectors = 0, miscompares = 0, edge_no = 0;
   bit have_op[2];
   int op_edge[2], nloop[2], prod[2], exp_prod[2];
   bit prod_valid[2];

   // Number of RUN cycles an operation needs (index 1 = SWAP_MIN instance).
   function automatic int loops(int d, int av, int bv);
      if (av == 0 || bv == 0) return 0;
      if (d == 1) return (av < bv) ? av : bv;
      return bv;
   endfunction

   function automatic int rand_op();
      int r = $urandom_range(0, 9);
      if (r == 0) return 0;
      if (r == 1) return 255;
      return $urandom_range(1, 12);
   endfunction

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         have_op[d] = 1'b0; exp_prod[d] = 0; prod_valid[d] = 1'b1;
      end
   endtask

   // Advance one clock: update the model with the inputs seen at the edge,
   // then compare every output of both instances shortly after the edge.
   task automatic tick();
      bit eb, ed;
      @(posedge clk);
      edge_no++;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            have_op[d] = 1'b0; exp_prod[d] = 0; prod_valid[d] = 1'b1;
         end else begin
            if (start[d] && (!have_op[d] || edge_no >= op_edge[d] + nloop[d] + 2)) begin
               have_op[d]    = 1'b1;
               op_edge[d]    = edge_no;
               nloop[d]      = loops(d, int'(a[d]), int'(b[d]));
               prod[d]       = int'(a[d]) * int'(b[d]);
               prod_valid[d] = 1'b0;
            end
            if (have_op[d] && edge_no == op_edge[d] + nloop[d]) begin
               exp_prod[d]   = prod[d];
               prod_valid[d] = 1'b1;
            end
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         eb = have_op[d] && edge_no >= op_edge[d] && edge_no < op_edge[d] + nloop[d];
         ed = have_op[d] && edge_no == op_edge[d] + nloop[d];
         chk($sformatf("busy%0d", d), int'(busy[d]), int'(eb));
         chk($sformatf("done%0d", d), int'(done[d]), int'(ed));
         if (prod_valid[d]) chk($sformatf("product%0d", d), int'(product[d]), exp_prod[d]);
      end
   endtask

   // One full operation on instance d with hand-computed expectations.
   task automatic run_op(int d, int av, int bv, int ep, int en);
      int k = 0;
      bit sb;
      a[d] = W'(av); b[d] = W'(bv); start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      a[d] = W'($urandom); b[d] = W'($urandom);
      sb = busy[d];
      while (!done[d] && k < 300) begin
         tick();
         k++;
         sb |= busy[d];
      end
      chk($sformatf("latency%0d_%0dx%0d", d, av, bv), k, en);
      chk($sformatf("result%0d_%0dx%0d", d, av, bv), int'(product[d]), ep);
      chk($sformatf("busy_seen%0d_%0dx%0d", d, av, bv), int'(sb), int'(en > 0));
      tick();
   endtask

   initial begin
      int k;
      int av, bv;
      rst = 1'b1; start = '0; a = '0; b = '0;
      model_reset();
      tick(); tick();
      for (int d = 0; d < 2; d++) begin
         chk("reset_product", int'(product[d]), 0);
         chk("reset_busy", int'(busy[d]), 0);
      end
      rst = 1'b0;
      tick();

      // Case 1/2/3/4 with literal expectations
      run_op(0, 7, 5, 35, 5);
      run_op(1, 200, 3, 600, 3);
      run_op(0, 3, 200, 600, 200);
      run_op(1, 5, 5, 25, 5);
      run_op(0, 0, 255, 0, 0);
      run_op(0, 255, 0, 0, 0);
      run_op(1, 0, 255, 0, 0);
      run_op(1, 255, 0, 0, 0);
      run_op(0, 255, 255, 65025, 255);
      run_op(1, 255, 255, 65025, 255);

      // Case 5: start during RUN is ignored
      a[0] = 8'd9; b[0] = 8'd4; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      a[0] = 8'd1; b[0] = 8'd1; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      k = 0;
      while (!done[0] && k < 50) begin tick(); k++; end
      chk("ignored_start_product", int'(product[0]), 36);
      tick();
      run_op(0, 1, 1, 1, 1);

      // Case 6: asynchronous reset mid-RUN
      a[1] = 8'd10; b[1] = 8'd10; start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      tick(); tick();
      #3 rst = 1'b1;
      #1;
      model_reset();
      for (int d = 0; d < 2; d++) begin
         chk("async_rst_busy", int'(busy[d]), 0);
         chk("async_rst_done", int'(done[d]), 0);
         chk("async_rst_product", int'(product[d]), 0);
      end
      tick(); tick();
      rst = 1'b0;
      repeat (15) tick();
      run_op(1, 6, 7, 42, 6);

      // Random full operations
      for (int i = 0; i < 24; i++) begin
         int d = i % 2;
         av = $urandom_range(0, 15);
         bv = $urandom_range(0, 15);
         run_op(d, av, bv, av * bv, loops(d, av, bv));
      end

      // Random free-running start/operand traffic, model checks every cycle
      repeat (1500) begin
         for (int d = 0; d < 2; d++) begin
            start[d] = ($urandom_range(0, 3) == 0);
            a[d] = W'(rand_op());
            b[d] = W'(rand_op());
         end
         tick();
      end
      start = '0;
      repeat (600) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
